// File: rtl/md_pkg.sv
// Shared opcode encoding and helpers for the HI/LO multiply/divide unit.
package md_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CNT_W       = 4;

    localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 4'd5;
    localparam logic [OP_W-1:0] MD_MTHI  = 4'd6;
    localparam logic [OP_W-1:0] MD_MFLO  = 4'd7;
    localparam logic [OP_W-1:0] MD_MFHI  = 4'd8;
    localparam logic [OP_W-1:0] MD_MSUB  = 4'd9;

    // Ops that kick off a multi-cycle computation in the unit.
    function automatic logic is_md_start(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_MSUB);
    endfunction

    // Ops that occupy the unit for the short (multiply) window.
    function automatic logic is_mult_class(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/md_busy_shadow.sv
// Shadow busy tracker: predicts the unit's busy window and flags disagreement.
module md_busy_shadow
    import md_pkg::*;
#(
    parameter int unsigned MULT_N = MULT_CYCLES,
    parameter int unsigned DIV_N  = DIV_CYCLES,
    parameter int unsigned CW     = CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] md_op_e,
    input  logic            busy_in,
    output logic            busy_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          busy_err_nx;

    // State, counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy_err <= busy_err_nx;
        end
    end

    // Next state: load on start, count down the busy window, compare with the unit.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        busy_err_nx = busy_err | ((state != ST_IDLE) != busy_in);
        if (start) begin
            // A start while busy means the stall was bypassed; resync and flag it.
            if (state != ST_IDLE) begin
                busy_err_nx = 1'b1;
            end
            if (is_mult_class(md_op_e)) begin
                state_nx = ST_MULT;
                cnt_nx   = CW'(MULT_N);
            end else begin
                state_nx = ST_DIV;
                cnt_nx   = CW'(DIV_N);
            end
        end else if (state != ST_IDLE) begin
            if (cnt == CW'(1)) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard control between the decoder and the HI/LO multiply/divide unit.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_N = MULT_CYCLES,
    parameter int unsigned DIV_N  = DIV_CYCLES,
    parameter int unsigned CW     = CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] md_op_d,
    input  logic            stall_ext,
    input  logic            busy_in,
    output logic [OP_W-1:0] md_op_e,
    output logic            start,
    output logic            stall_md,
    output logic            busy_err
);

    // E-stage slice of the D/E register; any stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset || stall_md || stall_ext) begin
            md_op_e <= MD_NONE;
        end else begin
            md_op_e <= md_op_d;
        end
    end

    // Start pulses for the single cycle a computing op sits in E.
    assign start = is_md_start(md_op_e);

    // Every md op in D, including HI/LO moves, waits out the unit's busy window.
    assign stall_md = (md_op_d != MD_NONE) && (start || busy_in);

    md_busy_shadow #(
        .MULT_N (MULT_N),
        .DIV_N  (DIV_N),
        .CW     (CW)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op_e  (md_op_e),
        .busy_in  (busy_in),
        .busy_err (busy_err)
    );

endmodule
